jam_sensor_conditioner: RTL and testbench
=========================================

// Module: jam_sensor_conditioner
// PURPOSE
//  Upstream front end of the traffic controller. Conditions four raw road-occupancy
//  detector inputs into the clean jam_sensor_0..3 levels consumed by the control unit
//  and the jam operation unit. Provides 2-flop synchronisation, per-road hysteresis
//  debounce (assert/release qualification), and stuck-high fault detection with a
//  fail-safe jam output.
// PARAMETERS
//  ON_CYCLES     8     consecutive synced-high cycles required to declare a jam (>=1)
//  OFF_CYCLES    16    consecutive synced-low cycles required to release a jam or clear a fault (>=1)
//  FAULT_CYCLES  1024  consecutive synced-high cycles that flag a stuck detector (> ON_CYCLES)
// PORTS
//  clk            in   1  system clock
//  rst_n          in   1  asynchronous active-low reset
//  raw_occ_0..3   in   1  raw occupancy detector per road; asynchronous and noisy
//  jam_sensor_0..3 out 1  registered, debounced jam indication per road
//  sensor_fault   out  4  registered stuck-high flag; bit i = road i
//  jam_count      out  3  number of jam_sensor_* currently high (0..4); combinational from the registered outputs
// BEHAVIOUR
//  Reset: all sync flops, counters, jam_sensor_* and sensor_fault are cleared to 0.
//   All per-road FSMs go to CLEAR. Reset asserts and clears immediately, mid-operation included.
//   Release is used synchronously through the existing reset scheme.
//  Sync: raw_occ_i passes through 2 flops to give s_i. All logic below sees s_i only.
//  Per-road FSM (4 identical instances; dbc_i is the debounce counter, wide enough for max(ON,OFF)):
//   CLEAR:      jam=0. s_i=1 -> PEND_JAM with dbc=1. If ON_CYCLES==1, go straight to JAMMED.
//   PEND_JAM:   s_i=1 -> dbc++. When dbc reaches ON_CYCLES -> JAMMED, dbc=0.
//               s_i=0 -> CLEAR, dbc=0.
//   JAMMED:     jam=1. s_i=0 -> PEND_CLEAR with dbc=1. If OFF_CYCLES==1, go straight to CLEAR.
//   PEND_CLEAR: jam=1. s_i=0 -> dbc++. When dbc reaches OFF_CYCLES -> CLEAR, dbc=0.
//               s_i=1 -> JAMMED, dbc=0.
//   jam_sensor_i is a registered output: it equals 1 in the cycle after entry to JAMMED
//   and stays 1 until the cycle after entry to CLEAR.
//  Latency: raw held high from just before edge k -> jam_sensor_i high after edge k+1+ON_CYCLES.
//   Release behaves the same way, using OFF_CYCLES.
//  Glitches: a single-cycle s_i change during PEND_* aborts qualification. The counter restarts from 0.
//  Fault counter hc_i ($clog2(FAULT_CYCLES+1) bits):
//   - Increments on every cycle with s_i=1 and clears on s_i=0.
//   - Saturates at FAULT_CYCLES; it never wraps.
//   - When hc_i reaches FAULT_CYCLES, sensor_fault[i] is set and the FSM is forced to CLEAR with
//     dbc=0, so jam_sensor_i=0. This is the fail-safe: the road returns to normal rotation.
//  While faulted:
//   - FSM is held in CLEAR and jam_sensor_i stays 0.
//   - sensor_fault[i] clears after OFF_CYCLES consecutive s_i=0 cycles, reusing dbc.
//   - The FSM is then in CLEAR and resumes normal operation on the next cycle.
//   - Any s_i=1 during this window restarts the low count.
//  Simultaneous events: fault detection has priority over the FSM transition in the same cycle.
//   Roads are fully independent; several may assert or release in the same cycle.
//  jam_count = jam_sensor_0 + jam_sensor_1 + jam_sensor_2 + jam_sensor_3, zero-extended to 3 bits.
// TESTING
//  1. Reset: raw=4'b1111, rst_n low for 3 cycles -> all outputs 0. Release -> jam_sensor_0..3 rise
//     after exactly ON_CYCLES+2 edges (10).
//  2. Qualify/abort: raw_occ_1 high for 7 cycles, low 1, high 8 -> no assert on the first burst;
//     assert 10 edges after the second burst starts. jam_count=1.
//  3. Release hysteresis: road 2 jammed; raw low 15 cycles, high 1, low 16 -> jam_sensor_2 stays 1
//     through the first dip and falls 18 edges after the final low starts.
//  4. Stuck detector: raw_occ_3 held high 1100 cycles -> jam_sensor_3 rises at edge 10, falls and
//     sensor_fault[3] sets at edge 1026. Then raw low 16 cycles -> fault clears. Re-jam needs the full ON_CYCLES.
//  5. Concurrency: all four roads staggered by 1 cycle -> jam_count steps 0->1->2->3->4 on
//     consecutive cycles. Release all -> counts back down to 0.
//  6. Mid-operation reset: assert rst_n low while roads 0 and 1 are in PEND_CLEAR -> outputs are 0
//     immediately. After release, counters restart from 0.

Source files
------------

// File: rtl/jam_sensor_conditioner_if.sv
// rtl/jam_sensor_conditioner_if.sv - detector/jam signal bundle for jam_sensor_conditioner
// Purpose: groups the raw detector inputs and the conditioned jam outputs.
// Signals:
//   raw_occ_0..3    raw occupancy detector level per road (asynchronous, noisy)
//   jam_sensor_0..3 debounced jam indication per road
//   sensor_fault    stuck-high flag, bit i = road i
//   jam_count       number of jam_sensor_* currently high (0..4)
// Modports: master drives the detectors and observes results; slave is the conditioner.
interface jam_sensor_conditioner_if;
    logic       raw_occ_0;
    logic       raw_occ_1;
    logic       raw_occ_2;
    logic       raw_occ_3;
    logic       jam_sensor_0;
    logic       jam_sensor_1;
    logic       jam_sensor_2;
    logic       jam_sensor_3;
    logic [3:0] sensor_fault;
    logic [2:0] jam_count;

    modport master (
        output raw_occ_0, raw_occ_1, raw_occ_2, raw_occ_3,
        input  jam_sensor_0, jam_sensor_1, jam_sensor_2, jam_sensor_3,
        input  sensor_fault, jam_count
    );

    modport slave (
        input  raw_occ_0, raw_occ_1, raw_occ_2, raw_occ_3,
        output jam_sensor_0, jam_sensor_1, jam_sensor_2, jam_sensor_3,
        output sensor_fault, jam_count
    );
endinterface

// File: rtl/jam_sensor_conditioner.sv
// rtl/jam_sensor_conditioner.sv - road-occupancy detector conditioner with debounce and stuck-high detection
// Purpose: synchronises four raw detector inputs, qualifies jam assert/release with
// hysteresis counters, and flags detectors stuck high (forcing their jam output low).
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    jam_sensor_conditioner_if.slave (raw_occ_* in; jam_sensor_*, sensor_fault, jam_count out)
module jam_sensor_conditioner #(
    parameter int ON_CYCLES    = 8,
    parameter int OFF_CYCLES   = 16,
    parameter int FAULT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    jam_sensor_conditioner_if.slave   bus
);
    localparam int DBC_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int DBC_W   = $clog2(DBC_MAX + 1);
    localparam int HC_W    = $clog2(FAULT_CYCLES + 1);

    localparam logic [DBC_W-1:0] ON_MAX    = DBC_W'(ON_CYCLES);
    localparam logic [DBC_W-1:0] OFF_MAX   = DBC_W'(OFF_CYCLES);
    localparam logic [DBC_W-1:0] DBC_ONE   = DBC_W'(1);
    localparam logic [HC_W-1:0]  FAULT_MAX = HC_W'(FAULT_CYCLES);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_PEND_JAM,
        ST_JAMMED,
        ST_PEND_CLEAR
    } state_t;

    logic [3:0] raw;
    logic [3:0] sync1_d, sync1_q;
    logic [3:0] sync2_d, sync2_q;

    state_t            state_d [4];
    state_t            state_q [4];
    logic [DBC_W-1:0]  dbc_d   [4];
    logic [DBC_W-1:0]  dbc_q   [4];
    logic [HC_W-1:0]   hc_d    [4];
    logic [HC_W-1:0]   hc_q    [4];
    logic              jam_d   [4];
    logic              jam_q   [4];
    logic              fault_d [4];
    logic              fault_q [4];

    assign raw = {bus.raw_occ_3, bus.raw_occ_2, bus.raw_occ_1, bus.raw_occ_0};

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_road
        logic             s;
        logic [DBC_W-1:0] dbc_inc;

        assign s       = sync2_q[i];
        assign dbc_inc = dbc_q[i] + DBC_ONE;

        always_comb begin
            state_d[i] = state_q[i];
            dbc_d[i]   = dbc_q[i];
            fault_d[i] = fault_q[i];

            // Stuck-high counter saturates so a permanently high detector stays faulted.
            if (!s) begin
                hc_d[i] = '0;
            end else if (hc_q[i] == FAULT_MAX) begin
                hc_d[i] = hc_q[i];
            end else begin
                hc_d[i] = hc_q[i] + HC_W'(1);
            end

            if (hc_d[i] == FAULT_MAX) begin
                // Fault wins over any debounce transition this cycle.
                fault_d[i] = 1'b1;
                state_d[i] = ST_CLEAR;
                dbc_d[i]   = '0;
            end else if (fault_q[i]) begin
                // Faulted: dbc counts consecutive lows to clear the fault; road held clear.
                state_d[i] = ST_CLEAR;
                if (s) begin
                    dbc_d[i] = '0;
                end else if (dbc_inc == OFF_MAX) begin
                    fault_d[i] = 1'b0;
                    dbc_d[i]   = '0;
                end else begin
                    dbc_d[i] = dbc_inc;
                end
            end else begin
                case (state_q[i])
                    ST_CLEAR: begin
                        if (s) begin
                            if (ON_MAX == DBC_ONE) begin
                                state_d[i] = ST_JAMMED;
                                dbc_d[i]   = '0;
                            end else begin
                                state_d[i] = ST_PEND_JAM;
                                dbc_d[i]   = DBC_ONE;
                            end
                        end
                    end
                    ST_PEND_JAM: begin
                        if (!s) begin
                            state_d[i] = ST_CLEAR;
                            dbc_d[i]   = '0;
                        end else if (dbc_inc == ON_MAX) begin
                            state_d[i] = ST_JAMMED;
                            dbc_d[i]   = '0;
                        end else begin
                            dbc_d[i] = dbc_inc;
                        end
                    end
                    ST_JAMMED: begin
                        if (!s) begin
                            if (OFF_MAX == DBC_ONE) begin
                                state_d[i] = ST_CLEAR;
                                dbc_d[i]   = '0;
                            end else begin
                                state_d[i] = ST_PEND_CLEAR;
                                dbc_d[i]   = DBC_ONE;
                            end
                        end
                    end
                    ST_PEND_CLEAR: begin
                        if (s) begin
                            state_d[i] = ST_JAMMED;
                            dbc_d[i]   = '0;
                        end else if (dbc_inc == OFF_MAX) begin
                            state_d[i] = ST_CLEAR;
                            dbc_d[i]   = '0;
                        end else begin
                            dbc_d[i] = dbc_inc;
                        end
                    end
                    default: begin
                        state_d[i] = ST_CLEAR;
                        dbc_d[i]   = '0;
                    end
                endcase
            end

            // Output registered alongside the state so it tracks the state it enters.
            jam_d[i] = (state_d[i] == ST_JAMMED) || (state_d[i] == ST_PEND_CLEAR);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q[i] <= ST_CLEAR;
                dbc_q[i]   <= '0;
                hc_q[i]    <= '0;
                jam_q[i]   <= 1'b0;
                fault_q[i] <= 1'b0;
            end else begin
                state_q[i] <= state_d[i];
                dbc_q[i]   <= dbc_d[i];
                hc_q[i]    <= hc_d[i];
                jam_q[i]   <= jam_d[i];
                fault_q[i] <= fault_d[i];
            end
        end
    end

    assign bus.jam_sensor_0 = jam_q[0];
    assign bus.jam_sensor_1 = jam_q[1];
    assign bus.jam_sensor_2 = jam_q[2];
    assign bus.jam_sensor_3 = jam_q[3];
    assign bus.sensor_fault = {fault_q[3], fault_q[2], fault_q[1], fault_q[0]};
    assign bus.jam_count    = 3'(jam_q[0]) + 3'(jam_q[1]) + 3'(jam_q[2]) + 3'(jam_q[3]);
endmodule

// File: tb/tb_jam_sensor_conditioner.sv
// tb/tb_jam_sensor_conditioner.sv - self-checking bench for jam_sensor_conditioner
module tb_jam_sensor_conditioner;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    jam_sensor_conditioner_if bus ();

    jam_sensor_conditioner #(
        .ON_CYCLES    (8),
        .OFF_CYCLES   (16),
        .FAULT_CYCLES (1024)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] raw;
        int         ncyc;
        logic [3:0] jam;
        logic [3:0] fault;
        string      name;
    } vec_t;

    vec_t tbl[$];

    task automatic set_raw(input logic [3:0] r);
        bus.raw_occ_0 = r[0];
        bus.raw_occ_1 = r[1];
        bus.raw_occ_2 = r[2];
        bus.raw_occ_3 = r[3];
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] exp_jam, input logic [3:0] exp_fault);
        logic [3:0] got_jam;
        logic [2:0] exp_cnt;
        got_jam = {bus.jam_sensor_3, bus.jam_sensor_2, bus.jam_sensor_1, bus.jam_sensor_0};
        exp_cnt = 3'(exp_jam[0]) + 3'(exp_jam[1]) + 3'(exp_jam[2]) + 3'(exp_jam[3]);
        n_checks++;
        if (got_jam !== exp_jam) begin
            n_fail++;
            $display("FAIL %s jam_sensor: got %b expected %b", name, got_jam, exp_jam);
        end
        n_checks++;
        if (bus.sensor_fault !== exp_fault) begin
            n_fail++;
            $display("FAIL %s sensor_fault: got %b expected %b", name, bus.sensor_fault, exp_fault);
        end
        n_checks++;
        if (bus.jam_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s jam_count: got %0d expected %0d", name, bus.jam_count, exp_cnt);
        end
    endtask

    initial begin
        // Each row: drive rst_n/raw, advance ncyc rising edges, then compare.
        tbl.push_back('{1'b0, 4'b1111, 0,  4'b0000, 4'b0000, "rst_async"});
        tbl.push_back('{1'b0, 4'b1111, 3,  4'b0000, 4'b0000, "rst_hold"});
        tbl.push_back('{1'b1, 4'b1111, 9,  4'b0000, 4'b0000, "rel_edge9"});
        tbl.push_back('{1'b1, 4'b1111, 1,  4'b1111, 4'b0000, "rel_edge10"});
        tbl.push_back('{1'b1, 4'b0000, 17, 4'b1111, 4'b0000, "all_off_17"});
        tbl.push_back('{1'b1, 4'b0000, 1,  4'b0000, 4'b0000, "all_off_18"});
        tbl.push_back('{1'b1, 4'b0010, 7,  4'b0000, 4'b0000, "r1_burst7"});
        tbl.push_back('{1'b1, 4'b0000, 1,  4'b0000, 4'b0000, "r1_glitch"});
        tbl.push_back('{1'b1, 4'b0010, 9,  4'b0000, 4'b0000, "r1_burst2_9"});
        tbl.push_back('{1'b1, 4'b0010, 1,  4'b0010, 4'b0000, "r1_burst2_10"});
        tbl.push_back('{1'b1, 4'b0100, 9,  4'b0010, 4'b0000, "r2_on_9"});
        tbl.push_back('{1'b1, 4'b0100, 1,  4'b0110, 4'b0000, "r2_on_10"});
        tbl.push_back('{1'b1, 4'b0100, 7,  4'b0110, 4'b0000, "r1_off_17"});
        tbl.push_back('{1'b1, 4'b0100, 1,  4'b0100, 4'b0000, "r1_off_18"});
        tbl.push_back('{1'b1, 4'b0000, 15, 4'b0100, 4'b0000, "r2_dip15"});
        tbl.push_back('{1'b1, 4'b0100, 1,  4'b0100, 4'b0000, "r2_blip"});
        tbl.push_back('{1'b1, 4'b0000, 17, 4'b0100, 4'b0000, "r2_low17"});
        tbl.push_back('{1'b1, 4'b0000, 1,  4'b0000, 4'b0000, "r2_low18"});
        tbl.push_back('{1'b1, 4'b0001, 1,  4'b0000, 4'b0000, "stag_on1"});
        tbl.push_back('{1'b1, 4'b0011, 1,  4'b0000, 4'b0000, "stag_on2"});
        tbl.push_back('{1'b1, 4'b0111, 1,  4'b0000, 4'b0000, "stag_on3"});
        tbl.push_back('{1'b1, 4'b1111, 6,  4'b0000, 4'b0000, "stag_on9"});
        tbl.push_back('{1'b1, 4'b1111, 1,  4'b0001, 4'b0000, "stag_cnt1"});
        tbl.push_back('{1'b1, 4'b1111, 1,  4'b0011, 4'b0000, "stag_cnt2"});
        tbl.push_back('{1'b1, 4'b1111, 1,  4'b0111, 4'b0000, "stag_cnt3"});
        tbl.push_back('{1'b1, 4'b1111, 1,  4'b1111, 4'b0000, "stag_cnt4"});
        tbl.push_back('{1'b1, 4'b1110, 1,  4'b1111, 4'b0000, "stag_off1"});
        tbl.push_back('{1'b1, 4'b1100, 1,  4'b1111, 4'b0000, "stag_off2"});
        tbl.push_back('{1'b1, 4'b1000, 1,  4'b1111, 4'b0000, "stag_off3"});
        tbl.push_back('{1'b1, 4'b0000, 14, 4'b1111, 4'b0000, "stag_off17"});
        tbl.push_back('{1'b1, 4'b0000, 1,  4'b1110, 4'b0000, "stag_dn3"});
        tbl.push_back('{1'b1, 4'b0000, 1,  4'b1100, 4'b0000, "stag_dn2"});
        tbl.push_back('{1'b1, 4'b0000, 1,  4'b1000, 4'b0000, "stag_dn1"});
        tbl.push_back('{1'b1, 4'b0000, 1,  4'b0000, 4'b0000, "stag_dn0"});

        set_raw(4'b0000);
        #2;
        for (int v = 0; v < tbl.size(); v++) begin
            rst_n = tbl[v].rst_n;
            set_raw(tbl[v].raw);
            if (tbl[v].ncyc == 0) #1;
            else wait_edges(tbl[v].ncyc);
            chk(tbl[v].name, tbl[v].jam, tbl[v].fault);
        end

        // Stuck detector on road 3: jams, then faults and drops at edge 1026.
        set_raw(4'b1000);
        wait_edges(9);    chk("stuck_e9",    4'b0000, 4'b0000);
        wait_edges(1);    chk("stuck_e10",   4'b1000, 4'b0000);
        wait_edges(1015); chk("stuck_e1025", 4'b1000, 4'b0000);
        wait_edges(1);    chk("stuck_e1026", 4'b0000, 4'b1000);
        wait_edges(74);   chk("stuck_e1100", 4'b0000, 4'b1000);

        // Low window interrupted by one high cycle restarts the clear count.
        set_raw(4'b0000); wait_edges(10);
        set_raw(4'b1000); wait_edges(1);
        set_raw(4'b0000);
        wait_edges(17);   chk("fclr_e28", 4'b0000, 4'b1000);
        wait_edges(1);    chk("fclr_e29", 4'b0000, 4'b0000);

        // Re-jam after the fault clears needs the full qualification.
        set_raw(4'b1000);
        wait_edges(9);    chk("rejam_e9",  4'b0000, 4'b0000);
        wait_edges(1);    chk("rejam_e10", 4'b1000, 4'b0000);
        set_raw(4'b0000);
        wait_edges(17);   chk("rejam_off17", 4'b1000, 4'b0000);
        wait_edges(1);    chk("rejam_off18", 4'b0000, 4'b0000);

        // Reset while roads 0 and 1 are in release qualification.
        set_raw(4'b0011);
        wait_edges(10);   chk("mid_jam",  4'b0011, 4'b0000);
        set_raw(4'b0000);
        wait_edges(5);    chk("mid_pend", 4'b0011, 4'b0000);
        rst_n = 1'b0;
        #1;               chk("mid_rst_async", 4'b0000, 4'b0000);
        wait_edges(2);    chk("mid_rst_hold",  4'b0000, 4'b0000);
        rst_n = 1'b1;
        set_raw(4'b0011);
        wait_edges(9);    chk("mid_rel_e9",  4'b0000, 4'b0000);
        wait_edges(1);    chk("mid_rel_e10", 4'b0011, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
